// File: rtl/mem_bus_pkg.sv
// Shared definitions for the memory bus master.
//   state_t    : bus cycle phases. The encoding is fixed (IDLE=0 .. HOLD=3).
//   MIN_WAIT   : smallest legal strobe length, in clk cycles.
//   wait_width : width of a counter that can hold the longer of the two waits.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int MIN_WAIT = 1;

  function automatic int wait_width(input int read_wait, input int write_wait);
    int max_wait;
    max_wait = (read_wait > write_wait) ? read_wait : write_wait;
    return $clog2(max_wait + 1);
  endfunction

endpackage

// File: rtl/mem_bus_master_if.sv
// Request/response handshake between the CPU/loader and the memory bus master.
//   req_valid/req_ready : single-cycle acceptance handshake
//   req_write           : 1 = write, 0 = read
//   req_addr, req_wdata : transaction address and write data
//   done                : one-cycle completion pulse
//   rdata               : data returned by the most recent read
// The 'master' modport is the requester; 'slave' is the bus master block.
interface mem_bus_master_if #(
  parameter int AddressSize = 16,
  parameter int WordSize    = 8
);

  logic                   req_valid;
  logic                   req_ready;
  logic                   req_write;
  logic [AddressSize-1:0] req_addr;
  logic [WordSize-1:0]    req_wdata;
  logic                   done;
  logic [WordSize-1:0]    rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, done, rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, done, rdata
  );

endinterface

// File: rtl/mem_wait_counter.sv
// Loadable down-counter that times the strobe phase of a bus cycle.
//   clk, reset : clock and synchronous active-high reset
//   load       : load load_value (has priority over en)
//   load_value : value to load
//   en         : decrement by one; the counter stops at zero
//   zero       : count is zero
module mem_wait_counter #(
  parameter int Width = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [Width-1:0] load_value,
  input  logic             en,
  output logic             zero
);

  logic [Width-1:0] count;

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge values of the others, which is how the hardware behaves.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - Width'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_bus_master.sv
// Synchronous initiator for the asynchronous active-low memory bus.
// Each accepted request becomes SETUP (1 cycle, CS_bar low), STROBE
// (ReadWait/WriteWait cycles, OE_bar or WE_bar low) and HOLD (1 cycle, strobes
// high, done pulsed). One transaction in flight at a time.
//   clk, reset        : clock and synchronous active-high reset
//   req               : request handshake (slave side of mem_bus_master_if)
//   Address           : registered memory address bus
//   Data              : bidirectional data bus, driven only by writes
//   CS_bar/OE_bar/WE_bar : registered active-low chip select / output / write enables
module mem_bus_master
  import mem_bus_pkg::*;
#(
  parameter int AddressSize = 16,
  parameter int WordSize    = 8,
  parameter int ReadWait    = 3,
  parameter int WriteWait   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  mem_bus_master_if.slave        req,
  output logic [AddressSize-1:0] Address,
  inout  wire  [WordSize-1:0]    Data,
  output logic                   CS_bar,
  output logic                   OE_bar,
  output logic                   WE_bar
);

  localparam int WaitWidth = wait_width(ReadWait, WriteWait);

  if ((ReadWait < MIN_WAIT) || (WriteWait < MIN_WAIT)) begin : g_bad_wait
    $error("mem_bus_master: ReadWait and WriteWait must both be at least 1");
  end

  state_t              state, state_next;
  logic                write_q, write_next;
  logic [WordSize-1:0] wdata_q;
  logic                drive_q;
  logic                accept;
  logic                cnt_load, cnt_en, cnt_zero;
  logic [WaitWidth-1:0] cnt_load_value;

  // The counter is loaded with Wait-1 so that STROBE, which exits on the
  // zero flag, lasts exactly Wait cycles.
  mem_wait_counter #(.Width(WaitWidth)) u_wait (
    .clk        (clk),
    .reset      (reset),
    .load       (cnt_load),
    .load_value (cnt_load_value),
    .en         (cnt_en),
    .zero       (cnt_zero)
  );

  // NOTE: every signal written here gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_next     = state;
    accept         = 1'b0;
    cnt_load       = 1'b0;
    cnt_en         = 1'b0;
    cnt_load_value = write_q ? WaitWidth'(WriteWait - 1) : WaitWidth'(ReadWait - 1);
    case (state)
      IDLE: begin
        if (req.req_valid) begin
          accept     = 1'b1;
          state_next = SETUP;
        end
      end
      SETUP: begin
        cnt_load   = 1'b1;
        state_next = STROBE;
      end
      STROBE: begin
        cnt_en = 1'b1;
        if (cnt_zero) state_next = HOLD;
      end
      HOLD:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    write_next = accept ? req.req_write : write_q;
  end

  // Bus outputs are decoded from the next state and registered, so each
  // strobe changes cleanly on the clock edge that enters its phase.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      drive_q   <= 1'b0;
      Address   <= '0;
      CS_bar    <= 1'b1;
      OE_bar    <= 1'b1;
      WE_bar    <= 1'b1;
      req.done  <= 1'b0;
      req.rdata <= '0;
    end else begin
      state   <= state_next;
      write_q <= write_next;
      if (accept) begin
        Address <= req.req_addr;
        wdata_q <= req.req_wdata;
      end
      // Capture on the edge that ends the last STROBE cycle, while OE_bar is
      // still low and the memory is still driving.
      if ((state == STROBE) && cnt_zero && !write_q) begin
        req.rdata <= Data;
      end
      CS_bar   <= !((state_next == SETUP) || (state_next == STROBE));
      OE_bar   <= !((state_next == STROBE) && !write_next);
      WE_bar   <= !((state_next == STROBE) && write_next);
      req.done <= (state_next == HOLD);
      drive_q  <= write_next && (state_next != IDLE);
    end
  end

  assign req.req_ready = (state == IDLE);
  assign Data          = drive_q ? wdata_q : 'z;

endmodule
